// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag
//   Captures one finished 8x8 signed Q20.32 DCT coefficient block, multiplies
//   each coefficient by a per-position unsigned Q1.16 reciprocal, rounds half
//   toward +inf, saturates to OUT_W bits and streams the 64 results in JPEG
//   zigzag order over a valid/ready handshake.
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   coef_in[u][v]          block coefficients, u = row
//   coef_valid / in_ready  one-cycle block-present pulse / block will be taken
//   recip_tbl[u][v]        reciprocal table, held static while busy
//   q_coef, q_index        quantized value and its zigzag position
//   q_sat, q_last          value was clipped / final beat of the block
//   q_valid / q_ready      output handshake
//   overrun                pulses the cycle after a block was offered but refused
// Only BLOCK_SIZE = 8 is meaningful: the zigzag ROM is a fixed 64-entry table.
module dct_quant_zigzag #(
    parameter int BLOCK_SIZE = 8,
    parameter int COEF_W     = 52,
    parameter int FRAC_BITS  = 32,
    parameter int RECIP_W    = 17,
    parameter int OUT_W      = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [COEF_W-1:0] coef_in   [BLOCK_SIZE][BLOCK_SIZE],
    input  logic                     coef_valid,
    output logic                     in_ready,
    input  logic [RECIP_W-1:0]       recip_tbl [BLOCK_SIZE][BLOCK_SIZE],
    output logic signed [OUT_W-1:0]  q_coef,
    output logic [5:0]               q_index,
    output logic                     q_sat,
    output logic                     q_last,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     overrun
);

    localparam int PROD_W = COEF_W + RECIP_W + 1;
    localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (FRAC_BITS + 15);
    localparam logic signed [PROD_W-1:0] QMAX     = PROD_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] QMIN     = ~QMAX;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t                   state_q, state_d;
    logic signed [COEF_W-1:0] buf_q [BLOCK_SIZE][BLOCK_SIZE];
    logic signed [OUT_W-1:0]  q_coef_q, q_coef_d;
    logic [5:0]               q_index_q, q_index_d;
    logic                     q_sat_q, q_sat_d;
    logic                     q_valid_q, q_valid_d;
    logic                     overrun_q, overrun_d;

    logic                     capture;
    logic                     load;
    logic [5:0]               k_sel;
    logic [5:0]               raster;
    logic signed [COEF_W-1:0] coef_sel;
    logic [RECIP_W-1:0]       recip_sel;
    logic signed [PROD_W-1:0] prod, rnd, r;
    logic signed [OUT_W-1:0]  quant;
    logic                     quant_sat;

    // zigzag position -> raster index (8*u + v)
    function automatic logic [5:0] zz_raster(input logic [5:0] k);
        logic [5:0] ri;
        ri = '0;
        case (k)
            6'd0:  ri = 6'd0;   6'd1:  ri = 6'd1;   6'd2:  ri = 6'd8;   6'd3:  ri = 6'd16;
            6'd4:  ri = 6'd9;   6'd5:  ri = 6'd2;   6'd6:  ri = 6'd3;   6'd7:  ri = 6'd10;
            6'd8:  ri = 6'd17;  6'd9:  ri = 6'd24;  6'd10: ri = 6'd32;  6'd11: ri = 6'd25;
            6'd12: ri = 6'd18;  6'd13: ri = 6'd11;  6'd14: ri = 6'd4;   6'd15: ri = 6'd5;
            6'd16: ri = 6'd12;  6'd17: ri = 6'd19;  6'd18: ri = 6'd26;  6'd19: ri = 6'd33;
            6'd20: ri = 6'd40;  6'd21: ri = 6'd48;  6'd22: ri = 6'd41;  6'd23: ri = 6'd34;
            6'd24: ri = 6'd27;  6'd25: ri = 6'd20;  6'd26: ri = 6'd13;  6'd27: ri = 6'd6;
            6'd28: ri = 6'd7;   6'd29: ri = 6'd14;  6'd30: ri = 6'd21;  6'd31: ri = 6'd28;
            6'd32: ri = 6'd35;  6'd33: ri = 6'd42;  6'd34: ri = 6'd49;  6'd35: ri = 6'd56;
            6'd36: ri = 6'd57;  6'd37: ri = 6'd50;  6'd38: ri = 6'd43;  6'd39: ri = 6'd36;
            6'd40: ri = 6'd29;  6'd41: ri = 6'd22;  6'd42: ri = 6'd15;  6'd43: ri = 6'd23;
            6'd44: ri = 6'd30;  6'd45: ri = 6'd37;  6'd46: ri = 6'd44;  6'd47: ri = 6'd51;
            6'd48: ri = 6'd58;  6'd49: ri = 6'd59;  6'd50: ri = 6'd52;  6'd51: ri = 6'd45;
            6'd52: ri = 6'd38;  6'd53: ri = 6'd31;  6'd54: ri = 6'd39;  6'd55: ri = 6'd46;
            6'd56: ri = 6'd53;  6'd57: ri = 6'd60;  6'd58: ri = 6'd61;  6'd59: ri = 6'd54;
            6'd60: ri = 6'd47;  6'd61: ri = 6'd55;  6'd62: ri = 6'd62;  6'd63: ri = 6'd63;
            default: ri = '0;
        endcase
        return ri;
    endfunction

    // The last beat's handshake frees the buffer in the same cycle, so a new
    // block can be taken back-to-back.
    assign in_ready = (state_q == IDLE) ||
                      ((state_q == EMIT) && (q_index_q == 6'd63) && q_ready);
    assign capture  = coef_valid && in_ready;

    // Quantizer for the coefficient at zigzag position k_sel.
    always_comb begin
        raster    = zz_raster(k_sel);
        coef_sel  = buf_q[raster[5:3]][raster[2:0]];
        recip_sel = recip_tbl[raster[5:3]][raster[2:0]];
        prod      = PROD_W'(coef_sel) * PROD_W'($signed({1'b0, recip_sel}));
        rnd       = prod + RND_HALF;
        r         = rnd >>> (FRAC_BITS + 16);
        quant_sat = 1'b0;
        if (r > QMAX) begin
            quant     = QMAX[OUT_W-1:0];
            quant_sat = 1'b1;
        end else if (r < QMIN) begin
            quant     = QMIN[OUT_W-1:0];
            quant_sat = 1'b1;
        end else begin
            quant     = r[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        q_coef_d  = q_coef_q;
        q_index_d = q_index_q;
        q_sat_d   = q_sat_q;
        q_valid_d = q_valid_q;
        overrun_d = coef_valid && !in_ready;
        load      = 1'b0;
        k_sel     = '0;
        case (state_q)
            IDLE: begin
                if (coef_valid) state_d = LOAD;
            end
            LOAD: begin
                load      = 1'b1;
                q_valid_d = 1'b1;
                state_d   = EMIT;
            end
            EMIT: begin
                if (q_ready) begin
                    if (q_index_q == 6'd63) begin
                        q_valid_d = 1'b0;
                        state_d   = coef_valid ? LOAD : IDLE;
                    end else begin
                        load  = 1'b1;
                        k_sel = q_index_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            q_coef_d  = quant;
            q_sat_d   = quant_sat;
            q_index_d = k_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            q_coef_q  <= '0;
            q_index_q <= '0;
            q_sat_q   <= 1'b0;
            q_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_coef_q  <= q_coef_d;
            q_index_q <= q_index_d;
            q_sat_q   <= q_sat_d;
            q_valid_q <= q_valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Block buffer carries no reset: its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (capture) buf_q <= coef_in;
    end

    assign q_coef  = q_coef_q;
    assign q_index = q_index_q;
    assign q_sat   = q_sat_q;
    assign q_valid = q_valid_q;
    assign q_last  = q_valid_q && (q_index_q == 6'd63);
    assign overrun = overrun_q;

endmodule
